// File: rtl/ecu_seq_if.sv
// Memory byte-fetch bus between the ECU sequencer (master) and the byte port (slave).
`timescale 1ns/1ps
interface ecu_seq_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              fetch_req;
    logic              pc_inc;
    logic              pc_load;

    modport master (
        input  mem_data, mem_ready,
        output fetch_req, pc_inc, pc_load
    );

    modport slave (
        output mem_data, mem_ready,
        input  fetch_req, pc_inc, pc_load
    );
endinterface

// File: rtl/ecu_seq.sv
// ECU instruction sequencer: fetches opcode/operands, owns the microcode step counter.
// Optional ECU_SEQ_STEP_GUARD_EN: step overflow sets a sticky fault and halts.
`timescale 1ns/1ps
module ecu_seq #(
    parameter int DATA_W  = 8,
    parameter int STEP_W  = 3,
    parameter int MAX_OPS = 3
) (
    input  logic              clk,
    input  logic              rst,
    ecu_seq_if.master         bus,
    input  logic [1:0]        len,
    input  logic              pc_lrc,
    input  logic              pc_ini,
    input  logic              pc_cub,
    input  logic              stall,
    input  logic              halt_req,
    output logic [DATA_W-1:0] insn,
    output logic [DATA_W-1:0] d1,
    output logic [DATA_W-1:0] d2,
    output logic [DATA_W-1:0] d3,
    output logic [STEP_W-1:0] step,
    output logic              halted,
    output logic              fault
);

    localparam int LEN_W = $clog2(MAX_OPS + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_OPS);

    typedef enum logic [2:0] {
        S_FETCH_OP,
        S_DECODE,
        S_FETCH_D,
        S_EXEC,
        S_HALT
    } state_e;

    state_e              r_state;
    state_e              w_next;
    logic                r_fetch_req;
    logic [DATA_W-1:0]   r_insn;
    logic [DATA_W-1:0]   r_d [MAX_OPS];
    logic [LEN_W-1:0]    r_idx;
    logic [LEN_W-1:0]    r_len;
    logic [STEP_W-1:0]   r_step;

    logic                w_accept;
    logic                w_exec;
    logic                w_end_insn;
    logic                w_step_inc;
    logic [LEN_W-1:0]    w_len_clamp;

    assign w_exec      = (r_state == S_EXEC);
    // fetch_req is only ever high in the two fetch states, so accept needs no state qualifier
    assign w_accept    = r_fetch_req & bus.mem_ready;
    assign w_end_insn  = w_exec & (pc_lrc | pc_ini);
    assign w_step_inc  = w_exec & ~pc_lrc & ~pc_ini & (pc_cub | ~stall);
    assign w_len_clamp = (int'(len) > MAX_OPS) ? MAX_LEN : LEN_W'(len);

`ifdef ECU_SEQ_STEP_GUARD_EN
    logic r_fault;
    logic w_step_wrap;
    assign w_step_wrap = w_step_inc & (r_step == '1);
    assign fault       = r_fault;
`else
    assign fault       = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH_OP: if (w_accept) w_next = S_DECODE;
            S_DECODE:   w_next = (w_len_clamp == '0) ? S_EXEC : S_FETCH_D;
            S_FETCH_D:  if (w_accept && (r_idx == r_len - 1'b1)) w_next = S_EXEC;
            S_EXEC: begin
                if (w_end_insn) begin
                    w_next = halt_req ? S_HALT : S_FETCH_OP;
                end
`ifdef ECU_SEQ_STEP_GUARD_EN
                else if (w_step_wrap) begin
                    w_next = S_HALT;
                end
`endif
            end
            S_HALT: begin
                if (!halt_req) w_next = S_FETCH_OP;
`ifdef ECU_SEQ_STEP_GUARD_EN
                if (r_fault) w_next = S_HALT;
`endif
            end
            default:    w_next = S_FETCH_OP;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_FETCH_OP;
            r_fetch_req <= 1'b0;
            r_insn      <= '0;
            // NOTE: the operand array is tiny and architecturally visible, so it is reset too.
            r_d         <= '{default: '0};
            r_idx       <= '0;
            r_len       <= '0;
            r_step      <= '0;
`ifdef ECU_SEQ_STEP_GUARD_EN
            r_fault     <= 1'b0;
`endif
        end else begin
            r_state     <= w_next;
            r_fetch_req <= (w_next == S_FETCH_OP) || (w_next == S_FETCH_D);
            case (r_state)
                S_FETCH_OP: begin
                    if (w_accept) begin
                        r_insn <= bus.mem_data;
                        r_d    <= '{default: '0};
                        r_idx  <= '0;
                    end
                end
                S_DECODE: begin
                    r_len <= w_len_clamp;
                    r_idx <= '0;
                end
                S_FETCH_D: begin
                    if (w_accept) begin
                        r_d[r_idx] <= bus.mem_data;
                        r_idx      <= r_idx + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_end_insn) begin
                        r_step <= '0;
                    end else if (w_step_inc) begin
                        r_step <= r_step + 1'b1;
                    end
`ifdef ECU_SEQ_STEP_GUARD_EN
                    if (w_step_wrap) r_fault <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // pc_lrc wins over pc_ini and pc_cub, so a combined end-of-instruction only loads the PC
    assign bus.fetch_req = r_fetch_req;
    assign bus.pc_inc    = w_accept | (w_exec & pc_cub & ~pc_lrc & ~pc_ini);
    assign bus.pc_load   = w_exec & pc_lrc;

    assign insn   = r_insn;
    assign d1     = r_d[0];
    assign d2     = r_d[1];
    assign d3     = r_d[2];
    assign step   = r_step;
    assign halted = (r_state == S_HALT);

endmodule

// File: tb/tb_ecu_seq.sv
// Directed bench for ecu_seq: fetch paths, operand stalls, EXEC priorities, halt and reset.
`timescale 1ns/1ps
module tb_ecu_seq;

    logic       clk;
    logic       rst;
    logic [1:0] len;
    logic       pc_lrc, pc_ini, pc_cub, stall, halt_req;
    logic [7:0] insn, d1, d2, d3;
    logic [2:0] step;
    logic       halted, fault;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int inc_cnt   = 0;
    int load_cnt  = 0;

    ecu_seq_if #(.DATA_W(8)) tif ();

    ecu_seq #(.DATA_W(8), .STEP_W(3), .MAX_OPS(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (tif.master),
        .len      (len),
        .pc_lrc   (pc_lrc),
        .pc_ini   (pc_ini),
        .pc_cub   (pc_cub),
        .stall    (stall),
        .halt_req (halt_req),
        .insn     (insn),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .step     (step),
        .halted   (halted),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on negedge, so the posedge sees stable pre-edge pulse values
    always @(posedge clk) begin
        if (tif.pc_inc === 1'b1)  inc_cnt++;
        if (tif.pc_load === 1'b1) load_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000ns");
        $fatal(1);
    end

    task automatic wait_req(input string tag);
        int n = 0;
        while (tif.fetch_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (tif.fetch_req !== 1'b1) $display("FAIL %s_wait_req: fetch_req=%b required 1 within 20 cycles", tag, tif.fetch_req);
        else pass_cnt++;
    endtask

    // Fetch a zero-operand opcode; returns at the negedge where EXEC shows step 0
    task automatic fetch_len0(input logic [7:0] op, input string tag);
        wait_req(tag);
        tif.mem_data  = op;
        tif.mem_ready = 1'b1;
        len           = 2'd0;
        @(negedge clk);
        tif.mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; len = '0; pc_lrc = 0; pc_ini = 0; pc_cub = 0; stall = 0; halt_req = 0;
        tif.mem_data = '0; tif.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({tif.fetch_req, tif.pc_inc, tif.pc_load, halted, fault} !== 5'b0) $display("FAIL reset_flags: req/inc/load/halted/fault=%b required 00000", {tif.fetch_req, tif.pc_inc, tif.pc_load, halted, fault});
        else pass_cnt++;
        total_cnt++;
        if ({insn, d1, d2, d3, step} !== 35'd0) $display("FAIL reset_regs: insn=%h d1=%h d2=%h d3=%h step=%0d required all 0", insn, d1, d2, d3, step);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (tif.fetch_req !== 1'b0) $display("FAIL reset_release_req: fetch_req=%b required 0", tif.fetch_req);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (tif.fetch_req !== 1'b1) $display("FAIL reset_first_req: fetch_req=%b required 1", tif.fetch_req);
        else pass_cnt++;
    endtask

    task automatic test_len0();
        int inc0 = inc_cnt;
        tif.mem_data = 8'h11; tif.mem_ready = 1'b1; len = 2'd0;
        #1;
        total_cnt++;
        if (tif.pc_inc !== 1'b1) $display("FAIL len0_opcode_inc: pc_inc=%b required 1", tif.pc_inc);
        else pass_cnt++;
        @(negedge clk);
        tif.mem_ready = 1'b0;
        #1;
        total_cnt++;
        if (insn !== 8'h11 || tif.fetch_req !== 1'b0 || tif.pc_inc !== 1'b0) $display("FAIL len0_decode: insn=%h req=%b inc=%b required 11/0/0", insn, tif.fetch_req, tif.pc_inc);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (step !== 3'd0 || tif.fetch_req !== 1'b0) $display("FAIL len0_exec: step=%0d req=%b required 0/0", step, tif.fetch_req);
        else pass_cnt++;
        pc_ini = 1'b1;
        @(negedge clk);
        pc_ini = 1'b0;
        total_cnt++;
        if (tif.fetch_req !== 1'b1 || inc_cnt - inc0 !== 1) $display("FAIL len0_pc_ini: req=%b pc_inc_count=%0d required 1/1", tif.fetch_req, inc_cnt - inc0);
        else pass_cnt++;
    endtask

    task automatic test_operands();
        int inc0 = inc_cnt;
        tif.mem_data = 8'h20; tif.mem_ready = 1'b1; len = 2'd2;
        @(negedge clk);
        tif.mem_ready = 1'b0;
        total_cnt++;
        if (insn !== 8'h20 || d1 !== 8'h00) $display("FAIL ops_opcode: insn=%h d1=%h required 20/00", insn, d1);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (tif.fetch_req !== 1'b1) $display("FAIL ops_fetch_d_req: fetch_req=%b required 1", tif.fetch_req);
        else pass_cnt++;
        tif.mem_data = 8'hAA; tif.mem_ready = 1'b1;
        @(negedge clk);
        tif.mem_ready = 1'b0;
        total_cnt++;
        if (d1 !== 8'hAA) $display("FAIL ops_d1: d1=%h required aa", d1);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (tif.pc_inc !== 1'b0 || tif.fetch_req !== 1'b1 || d2 !== 8'h00) $display("FAIL ops_ready_low: inc=%b req=%b d2=%h required 0/1/00", tif.pc_inc, tif.fetch_req, d2);
        else pass_cnt++;
        tif.mem_data = 8'hBB; tif.mem_ready = 1'b1;
        @(negedge clk);
        tif.mem_ready = 1'b0; len = 2'd0;
        total_cnt++;
        if (d1 !== 8'hAA || d2 !== 8'hBB || d3 !== 8'h00) $display("FAIL ops_bytes: d1=%h d2=%h d3=%h required aa/bb/00", d1, d2, d3);
        else pass_cnt++;
        total_cnt++;
        if (tif.fetch_req !== 1'b0 || step !== 3'd0 || inc_cnt - inc0 !== 3) $display("FAIL ops_exec_entry: req=%b step=%0d pc_inc_count=%0d required 0/0/3", tif.fetch_req, step, inc_cnt - inc0);
        else pass_cnt++;
    endtask

    task automatic test_lrc_ini();
        int inc0 = inc_cnt;
        int ld0  = load_cnt;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (step !== 3'(i)) $display("FAIL lrc_step_%0d: step=%0d required %0d", i, step, i);
            else pass_cnt++;
        end
        pc_lrc = 1'b1; pc_ini = 1'b1;
        #1;
        total_cnt++;
        if (tif.pc_load !== 1'b1 || tif.pc_inc !== 1'b0) $display("FAIL lrc_ini_pulses: load=%b inc=%b required 1/0", tif.pc_load, tif.pc_inc);
        else pass_cnt++;
        @(negedge clk);
        pc_lrc = 1'b0; pc_ini = 1'b0;
        total_cnt++;
        if (step !== 3'd0 || tif.fetch_req !== 1'b1 || load_cnt - ld0 !== 1 || inc_cnt - inc0 !== 0) $display("FAIL lrc_ini_end: step=%0d req=%b loads=%0d incs=%0d required 0/1/1/0", step, tif.fetch_req, load_cnt - ld0, inc_cnt - inc0);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        fetch_len0(8'h33, "halt");
        @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (step !== 3'd2 || halted !== 1'b0) $display("FAIL halt_mid_insn: step=%0d halted=%b required 2/0", step, halted);
        else pass_cnt++;
        pc_ini = 1'b1;
        @(negedge clk);
        pc_ini = 1'b0;
        total_cnt++;
        if (halted !== 1'b1 || tif.fetch_req !== 1'b0 || fault !== 1'b0) $display("FAIL halt_enter: halted=%b req=%b fault=%b required 1/0/0", halted, tif.fetch_req, fault);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (halted !== 1'b1 || tif.fetch_req !== 1'b0) $display("FAIL halt_hold: halted=%b req=%b required 1/0", halted, tif.fetch_req);
        else pass_cnt++;
        halt_req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (halted !== 1'b0 || tif.fetch_req !== 1'b1) $display("FAIL halt_exit: halted=%b req=%b required 0/1", halted, tif.fetch_req);
        else pass_cnt++;
    endtask

    task automatic test_cub_stall_overflow();
        int inc0;
        fetch_len0(8'h44, "ovf");
        inc0   = inc_cnt;
        pc_cub = 1'b1;
        #1;
        total_cnt++;
        if (tif.pc_inc !== 1'b1) $display("FAIL cub_pulse: pc_inc=%b required 1", tif.pc_inc);
        else pass_cnt++;
        @(negedge clk);
        pc_cub = 1'b0; stall = 1'b1;
        total_cnt++;
        if (step !== 3'd1) $display("FAIL cub_step: step=%0d required 1", step);
        else pass_cnt++;
        @(negedge clk);
        stall = 1'b0;
        total_cnt++;
        if (step !== 3'd1 || inc_cnt - inc0 !== 1) $display("FAIL stall_hold: step=%0d incs=%0d required 1/1", step, inc_cnt - inc0);
        else pass_cnt++;
        repeat (6) @(negedge clk);
        total_cnt++;
        if (step !== 3'd7) $display("FAIL ovf_step7: step=%0d required 7", step);
        else pass_cnt++;
        @(negedge clk);
`ifdef ECU_SEQ_STEP_GUARD_EN
        total_cnt++;
        if (fault !== 1'b1 || halted !== 1'b1) $display("FAIL ovf_guard: fault=%b halted=%b required 1/1", fault, halted);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (halted !== 1'b1 || fault !== 1'b1 || tif.fetch_req !== 1'b0) $display("FAIL ovf_sticky: halted=%b fault=%b req=%b required 1/1/0", halted, fault, tif.fetch_req);
        else pass_cnt++;
`else
        total_cnt++;
        if (step !== 3'd0 || halted !== 1'b0 || fault !== 1'b0) $display("FAIL ovf_wrap: step=%0d halted=%b fault=%b required 0/0/0", step, halted, fault);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (step !== 3'd1) $display("FAIL ovf_continue: step=%0d required 1", step);
        else pass_cnt++;
        pc_ini = 1'b1;
        @(negedge clk);
        pc_ini = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_fetch();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tif.mem_data = 8'h55; tif.mem_ready = 1'b1; len = 2'd3;
        @(negedge clk);
        tif.mem_ready = 1'b0;
        @(negedge clk);
        tif.mem_data = 8'h66; tif.mem_ready = 1'b1;
        @(negedge clk);
        tif.mem_data = 8'h77;
        total_cnt++;
        if (d1 !== 8'h66 || tif.fetch_req !== 1'b1) $display("FAIL rstmid_d1: d1=%h req=%b required 66/1", d1, tif.fetch_req);
        else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (tif.fetch_req !== 1'b0 || tif.pc_inc !== 1'b0 || {insn, d1, step} !== 19'd0) $display("FAIL rstmid_clear: req=%b inc=%b insn=%h d1=%h step=%0d required 0/0/00/00/0", tif.fetch_req, tif.pc_inc, insn, d1, step);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1; tif.mem_ready = 1'b0; len = 2'd0;
        @(negedge clk);
        fetch_len0(8'h77, "rstmid");
        total_cnt++;
        if (insn !== 8'h77 || d1 !== 8'h00 || step !== 3'd0 || halted !== 1'b0) $display("FAIL rstmid_restart: insn=%h d1=%h step=%0d halted=%b required 77/00/0/0", insn, d1, step, halted);
        else pass_cnt++;
        pc_ini = 1'b1;
        @(negedge clk);
        pc_ini = 1'b0;
    endtask

    initial begin
        test_reset();
        test_len0();
        test_operands();
        test_lrc_ini();
        test_halt();
        test_cub_stall_overflow();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
